// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle.
// Groups the ALU result input, the load response handshake, the register
// file write port and the occupancy/kill statistics.
//   master: execute/memory side (drives results, observes write port)
//   slave : the arbiter itself
interface wb_arbiter_if #(
  parameter int unsigned ad_width   = 5,
  parameter int unsigned data_width = 32,
  parameter int unsigned buf_depth  = 2
);
  localparam int unsigned cnt_w = $clog2(buf_depth) + 1;

  logic                  alu_valid;
  logic [ad_width-1:0]   alu_rd;
  logic [data_width-1:0] alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [ad_width-1:0]   ld_rd;
  logic [data_width-1:0] ld_data;
  logic                  write_enable;
  logic [ad_width-1:0]   write_address;
  logic [data_width-1:0] write_data;
  logic [cnt_w-1:0]      buf_count;
  logic [7:0]            kill_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, write_enable, write_address, write_data, buf_count, kill_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, write_enable, write_address, write_data, buf_count, kill_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register file write port and merges the
// never-stalling ALU result with buffered load responses.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    wb_arbiter_if.slave (ALU in, load valid/ready in, write port out,
//          buf_count / kill_count statistics out)
module wb_arbiter #(
  parameter int unsigned ad_width   = 5,
  parameter int unsigned data_width = 32,
  parameter int unsigned buf_depth  = 2
) (
  input  logic clk,
  input  logic reset,
  wb_arbiter_if.slave bus
);
  localparam int unsigned ptr_w = $clog2(buf_depth);
  localparam int unsigned cnt_w = $clog2(buf_depth) + 1;

  // Load buffer storage; ent_live marks occupied, not-yet-killed slots.
  logic [ad_width-1:0]   ent_rd_q   [buf_depth];
  logic [ad_width-1:0]   ent_rd_d   [buf_depth];
  logic [data_width-1:0] ent_data_q [buf_depth];
  logic [data_width-1:0] ent_data_d [buf_depth];
  logic [buf_depth-1:0]  ent_live_q, ent_live_d;

  logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0]      count_q, count_d;
  logic                  ld_ready_q, ld_ready_d;
  logic [7:0]            kill_count_q, kill_count_d;

  logic                  write_enable_q, write_enable_d;
  logic [ad_width-1:0]   write_address_q, write_address_d;
  logic [data_width-1:0] write_data_q, write_data_d;

  logic                  push, pop;
  logic [cnt_w-1:0]      n_kill;
  logic [31:0]           kill_total;

  assign bus.ld_ready      = ld_ready_q;
  assign bus.write_enable  = write_enable_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.buf_count     = count_q;
  assign bus.kill_count    = kill_count_q;

  // Selection, kill and buffer bookkeeping for the next edge.
  always_comb begin
    ent_rd_d        = ent_rd_q;
    ent_data_d      = ent_data_q;
    ent_live_d      = ent_live_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    n_kill          = '0;

    // ready comes from the registered count only, so a full buffer refuses
    // a load even in a cycle where it pops.
    push = bus.ld_valid && ld_ready_q;
    pop  = !bus.alu_valid && (count_q != '0);

    if (bus.alu_valid) begin
      if (bus.alu_rd != '0) begin
        write_enable_d  = 1'b1;
        write_address_d = bus.alu_rd;
        write_data_d    = bus.alu_data;
        // Older buffered loads to the same register are now stale.
        for (int i = 0; i < int'(buf_depth); i++) begin
          if (ent_live_q[i] && (ent_rd_q[i] == bus.alu_rd)) begin
            ent_live_d[i] = 1'b0;
            n_kill        = n_kill + cnt_w'(1);
          end
        end
      end
    end else if (pop) begin
      // Killed entries and x0 targets still consume their pop slot.
      if (ent_live_q[rd_ptr_q] && (ent_rd_q[rd_ptr_q] != '0)) begin
        write_enable_d  = 1'b1;
        write_address_d = ent_rd_q[rd_ptr_q];
        write_data_d    = ent_data_q[rd_ptr_q];
      end
      ent_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + ptr_w'(1);
    end

    // The pushed load is younger than this edge's ALU write; never killed.
    if (push) begin
      ent_rd_d[wr_ptr_q]   = bus.ld_rd;
      ent_data_d[wr_ptr_q] = bus.ld_data;
      ent_live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d             = wr_ptr_q + ptr_w'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase

    ld_ready_d = (count_d < cnt_w'(buf_depth));

    kill_total   = 32'(kill_count_q) + 32'(n_kill);
    kill_count_d = (kill_total > 32'd255) ? 8'd255 : 8'(kill_total);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(buf_depth); i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
      ent_live_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      ld_ready_q      <= 1'b1;
      kill_count_q    <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      ent_rd_q        <= ent_rd_d;
      ent_data_q      <= ent_data_d;
      ent_live_q      <= ent_live_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      ld_ready_q      <= ld_ready_d;
      kill_count_q    <= kill_count_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int unsigned aw    = 5;
  localparam int unsigned dw    = 32;
  localparam int unsigned depth = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.ad_width(aw), .data_width(dw), .buf_depth(depth)) bus ();
  wb_arbiter #(.ad_width(aw), .data_width(dw), .buf_depth(depth)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: load buffer as a queue of entries in arrival order.
  typedef struct {
    logic [aw-1:0] rd;
    logic [dw-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  bit            m_we = 0;
  logic [aw-1:0] m_wa = '0;
  logic [dw-1:0] m_wd = '0;
  int            m_kills = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_we = 0; m_wa = '0; m_wd = '0; m_kills = 0;
    end else begin
      bit   accept;
      ent_t e;
      accept = bus.ld_valid && (mq.size() < int'(depth));
      m_we   = 0;
      if (bus.alu_valid) begin
        if (bus.alu_rd != 0) begin
          m_we = 1; m_wa = bus.alu_rd; m_wd = bus.alu_data;
          foreach (mq[i]) if (mq[i].live && mq[i].rd == bus.alu_rd) begin
            mq[i].live = 0;
            m_kills++;
          end
        end
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live && e.rd != 0) begin
          m_we = 1; m_wa = e.rd; m_wd = e.data;
        end
      end
      if (accept) begin
        e.rd = bus.ld_rd; e.data = bus.ld_data; e.live = 1;
        mq.push_back(e);
      end
      if (m_kills > 255) m_kills = 255;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("we", 64'(bus.write_enable), 64'(m_we));
      chk("addr", 64'(bus.write_address), 64'(m_wa));
      chk("data", 64'(bus.write_data), 64'(m_wd));
      chk("count", 64'(bus.buf_count), 64'(mq.size()));
      chk("ready", 64'(bus.ld_ready), 64'(mq.size() < int'(depth)));
      chk("kills", 64'(bus.kill_count), 64'(m_kills));
      chk("count_bound", 64'(bus.buf_count <= depth), 64'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input int ard, input int ad,
                       input bit lv, input int lrd, input int ld);
    bus.alu_valid = av; bus.alu_rd = aw'(ard); bus.alu_data = dw'(ad);
    bus.ld_valid  = lv; bus.ld_rd  = aw'(lrd); bus.ld_data  = dw'(ld);
  endtask

  task automatic expect_wr(input string name, input bit we, input int wa, input int wd);
    chk({name, ".we"}, 64'(bus.write_enable), 64'(we));
    if (we) begin
      chk({name, ".addr"}, 64'(bus.write_address), 64'(wa));
      chk({name, ".data"}, 64'(bus.write_data), 64'(wd));
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst.ready", 64'(bus.ld_ready), 64'd1);
    chk("rst.we", 64'(bus.write_enable), 64'd0);
    chk("rst.count", 64'(bus.buf_count), 64'd0);
    chk("rst.kills", 64'(bus.kill_count), 64'd0);
    chk("rst.addr", 64'(bus.write_address), 64'd0);
    tick(); tick();
    reset = 1'b0;

    // ALU only
    drive(1, 5, 32'hA0, 0, 0, 0); tick();
    expect_wr("alu", 1, 5, 32'hA0);
    drive(0, 0, 0, 0, 0, 0); tick();
    expect_wr("alu_idle", 0, 0, 0);
    chk("alu_idle.hold_addr", 64'(bus.write_address), 64'd5);
    chk("alu_idle.hold_data", 64'(bus.write_data), 64'hA0);

    // Priority and backpressure
    drive(0, 0, 0, 1, 3, 32'h1234); tick();
    expect_wr("prio.acc", 0, 0, 0);
    chk("prio.count1", 64'(bus.buf_count), 64'd1);
    drive(1, 7, 32'h70, 1, 10, 32'h5678); tick();
    expect_wr("prio.w7", 1, 7, 32'h70);
    chk("prio.count2", 64'(bus.buf_count), 64'd2);
    chk("prio.full", 64'(bus.ld_ready), 64'd0);
    drive(1, 8, 32'h80, 1, 11, 32'h9); tick();
    expect_wr("prio.w8", 1, 8, 32'h80);
    chk("prio.refused", 64'(bus.buf_count), 64'd2);
    drive(1, 9, 32'h90, 1, 11, 32'h9); tick();
    expect_wr("prio.w9", 1, 9, 32'h90);
    drive(0, 0, 0, 0, 0, 0); tick();
    expect_wr("prio.w3", 1, 3, 32'h1234);
    chk("prio.ready_again", 64'(bus.ld_ready), 64'd1);
    tick();
    expect_wr("prio.w10", 1, 10, 32'h5678);
    chk("prio.empty", 64'(bus.buf_count), 64'd0);

    // Stale-load kill
    drive(0, 0, 0, 1, 4, 32'hDEAD); tick();
    drive(1, 4, 32'h40, 0, 0, 0); tick();
    expect_wr("kill.alu", 1, 4, 32'h40);
    chk("kill.count", 64'(bus.kill_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0); tick();
    expect_wr("kill.pop", 0, 0, 0);
    chk("kill.hold_data", 64'(bus.write_data), 64'h40);
    chk("kill.empty", 64'(bus.buf_count), 64'd0);

    // x0 handling
    drive(0, 0, 0, 1, 0, 32'h77); tick();
    expect_wr("x0.ld", 0, 0, 0);
    drive(1, 0, 32'h99, 0, 0, 0); tick();
    expect_wr("x0.alu", 0, 0, 0);
    chk("x0.head_held", 64'(bus.buf_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0); tick();
    expect_wr("x0.pop", 0, 0, 0);
    chk("x0.empty", 64'(bus.buf_count), 64'd0);
    chk("x0.kills", 64'(bus.kill_count), 64'd1);

    // Reset mid-stream with two loads buffered
    drive(1, 20, 32'h200, 1, 12, 32'hC); tick();
    drive(1, 21, 32'h210, 1, 13, 32'hD); tick();
    chk("mrst.pre_count", 64'(bus.buf_count), 64'd2);
    #1 reset = 1'b1;
    #1;
    chk("mrst.we", 64'(bus.write_enable), 64'd0);
    chk("mrst.count", 64'(bus.buf_count), 64'd0);
    chk("mrst.ready", 64'(bus.ld_ready), 64'd1);
    chk("mrst.kills", 64'(bus.kill_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    expect_wr("mrst.after", 0, 0, 0);

    // Random stress against the model
    for (int n = 0; n < 1000; n++) begin
      drive($urandom_range(0, 99) < 45, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 99) < 60, $urandom_range(0, 7), $urandom);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the register file write port (write_enable / write_address / write_data). It merges two result sources: the single-cycle ALU, which can never stall, and the variable-latency load unit, which uses a valid/ready handshake. Load responses that cannot be written immediately are held in a small FIFO. The block sits between the execute/memory stages and reg_file, and exposes buffer occupancy and kill statistics to hazard logic and to verification.

## Interface
- ad_width, 5: register address width
- data_width, 32: register data width
- buf_depth, 2: load buffer entries; power of two, ≥2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present this cycle; always accepted
- alu_rd  input  ad_width  ALU destination register
- alu_data  input  data_width  ALU result
- ld_valid  input  1  load response present
- ld_ready  output  1  buffer can accept a load response; high = count < buf_depth
- ld_rd  input  ad_width  load destination register
- ld_data  input  data_width  load data
- write_enable  output  1  registered; drives reg_file write_enable
- write_address  output  ad_width  registered; drives reg_file write_address
- write_data  output  data_width  registered; drives reg_file write_data
- buf_count  output  clog2(buf_depth)+1  current FIFO occupancy
- kill_count  output  8  saturating count of buffered loads killed by ALU overwrite

## Operation
- Reset, asynchronous: write_enable=0, write_address=0, write_data=0, FIFO empty, buf_count=0, kill_count=0. ld_ready=1 while and after reset.
- Load accept: on a rising edge with ld_valid && ld_ready, push {ld_rd, ld_data} to the FIFO tail.
- ld_ready depends only on the registered count. There is no combinational path from ld_valid or alu_valid, so a full FIFO refuses loads even in a cycle where it pops.
- Per-edge writeback selection, in priority order:
  1. alu_valid=1: issue the ALU result. FIFO head holds.
  2. alu_valid=0 and FIFO non-empty: pop the head and issue it.
  3. Otherwise: write_enable=0. write_address and write_data hold their previous values.
- Writes to x0: a selected result with rd=0 is consumed (a FIFO entry is still popped) but write_enable=0.
- Stale-load kill: when alu_valid=1 and alu_rd≠0, every FIFO entry that was present before this edge with rd==alu_rd is invalidated.
  - Invalid entries stay in the FIFO. When popped they produce write_enable=0 and use that pop slot.
  - kill_count increments by the number of entries killed at that edge, saturating at 255.
- A load accepted on the same edge as the ALU write is treated as younger and is not killed.
- FIFO pointers wrap modulo buf_depth. buf_count = pushes − pops, range 0..buf_depth.
- Simultaneous push and pop at the same edge: count is unchanged and both take effect.
- Reset mid-operation: all buffered loads are discarded and write_enable drops immediately (asynchronously).

## Timing
- ALU result sampled at edge E → write_enable/address/data valid after E → reg_file writes at edge E+1. Latency is 1 cycle.
- Load accepted at edge E → earliest issue at edge E+1, if alu_valid=0 in that cycle → reg_file writes at E+2.
- Each ALU-valid cycle delays a buffered load by exactly one cycle.
- Throughput is one write per cycle. Sustained alu_valid starves the FIFO. After buf_depth accepted loads, ld_ready=0 until a pop occurs.
- write_enable is a single-cycle pulse per issued write. Back-to-back writes keep it high.

## Test plan
- Reset: assert reset mid-stream with 2 loads buffered → write_enable=0 and buf_count=0 immediately; ld_ready=1.
- ALU only: alu_valid with rd=5, data=0x0000_00A0 at edge E → write_enable=1, write_address=5, write_data=0xA0 after E; write_enable=0 after E+1 if idle.
- Priority/backpressure: load rd=3 data=0x1234 accepted, then alu_valid for 3 cycles (rd=7,8,9) → writes 7, 8, 9 then 3.
  - During those cycles a second load is accepted; a third sees ld_ready=0.
- Kill: buffer load rd=4 data=0xDEAD, then alu rd=4 data=0x40 → reg 4 is written with 0x40 only; the later pop gives write_enable=0; kill_count=1.
- x0 handling: load rd=0 and alu rd=0 → never write_enable=1; buf_count returns to 0.
- Wrap/stress: 1000 cycles of random alu_valid/ld_valid against a reference model → write sequence matches the model, buf_count never exceeds buf_depth, and pointer wrap is correct.
